// File: rtl/cnn_layer_accel_seq_pkg.sv
// Shared definitions for the CNN layer config-sequence generator: word field
// layout, default geometry, FSM states and the word-pointer advance helper.
package cnn_layer_accel_seq_pkg;

    localparam int WORD_W  = 16;
    localparam int RM_BIT  = 12;
    localparam int RST_BIT = 11;
    localparam int P_BIT   = 10;
    localparam int SEQ_LSB = 0;
    localparam int SEQ_W   = 10;

    localparam int DEF_GROUP_LEN      = 5;
    localparam int DEF_WORDS_PER_BEAT = 8;
    localparam int DEF_NUM_BEATS      = 512;

    localparam int MAX_GROUPS = 512;
    localparam int GRP_W      = 10;
    localparam int POS_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIN
    } seq_state_t;

    // Position of one word in the global stream as (group, word-in-group).
    typedef struct packed {
        logic [GRP_W-1:0] grp;
        logic [POS_W-1:0] pos;
    } word_ptr_t;

    function automatic word_ptr_t next_ptr(input word_ptr_t p, input int group_len);
        word_ptr_t n;
        if (p.pos == POS_W'(group_len - 1)) begin
            n.grp = p.grp + GRP_W'(1);
            n.pos = '0;
        end else begin
            n.grp = p.grp;
            n.pos = p.pos + POS_W'(1);
        end
        return n;
    endfunction

    // Zero or an oversized request means "load the full table".
    function automatic logic [GRP_W-1:0] eff_groups(input logic [GRP_W-1:0] n);
        if (n == '0 || n > GRP_W'(MAX_GROUPS))
            return GRP_W'(MAX_GROUPS);
        return n;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_seq_word.sv
// Combinational encoder: (group, position-in-group, valid) -> one 16-bit
// sequence word. Invalid slots (past the last group) encode as zero padding.
module cnn_layer_accel_seq_word
    import cnn_layer_accel_seq_pkg::*;
(
    input  logic [GRP_W-1:0]  grp,
    input  logic [POS_W-1:0]  pos,
    input  logic              valid,
    output logic [WORD_W-1:0] word
);

    logic [SEQ_W-1:0] seq;

    // SEQ arithmetic is deliberately truncated to SEQ_W bits (wraps mod 1024).
    always_comb begin
        word = '0;
        seq  = '0;
        if (valid) begin
            case (pos)
                3'd0: begin
                    word[RST_BIT] = 1'b1;
                    word[P_BIT]   = ~grp[0];
                    seq           = grp;
                end
                3'd1: begin
                    word[P_BIT] = grp[0];
                    seq         = SEQ_W'(2) + {grp[SEQ_W-1:1], 1'b0};
                end
                3'd2: seq = grp + SEQ_W'(512);
                3'd3: seq = grp + SEQ_W'(513);
                3'd4: begin
                    word[RM_BIT] = 1'b1;
                    seq          = grp + SEQ_W'(514);
                end
                default: seq = '0;
            endcase
        end
        word[SEQ_LSB +: SEQ_W] = seq;
    end

endmodule

// File: rtl/cnn_layer_accel_seq_gen.sv
// Streams a fixed-length table of 128-bit config beats built from per-group
// sequence words, one beat per cycle under continuous accept.
module cnn_layer_accel_seq_gen
    import cnn_layer_accel_seq_pkg::*;
#(
    parameter int C_NUM_BEATS      = DEF_NUM_BEATS,
    parameter int C_WORDS_PER_BEAT = DEF_WORDS_PER_BEAT,
    parameter int C_GROUP_LEN      = DEF_GROUP_LEN
) (
    input  logic                                 clk_if,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [GRP_W-1:0]                     cfg_num_groups,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 config_valid,
    input  logic                                 config_accept,
    output logic [C_WORDS_PER_BEAT*WORD_W-1:0]   config_data
);

    localparam int              BEAT_W    = $clog2(C_NUM_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_NUM_BEATS - 1);

    seq_state_t        state;
    word_ptr_t         ptr_q;
    word_ptr_t         base_ptr;
    logic [GRP_W-1:0]  g_cnt_q;
    logic [GRP_W-1:0]  g_cnt;
    logic [BEAT_W-1:0] beat_cnt;

    word_ptr_t                                     slot_ptr [0:C_WORDS_PER_BEAT];
    logic [C_WORDS_PER_BEAT-1:0][WORD_W-1:0]       beat_nxt;

    logic beat_take;
    assign beat_take = config_valid && config_accept;

    // In IDLE the first beat is built straight from the incoming request so it
    // can be registered on the start cycle; afterwards from the saved pointer.
    always_comb begin
        base_ptr = ptr_q;
        g_cnt    = g_cnt_q;
        if (state == ST_IDLE) begin
            base_ptr = '0;
            g_cnt    = eff_groups(cfg_num_groups);
        end
    end

    assign slot_ptr[0] = base_ptr;

    generate
        for (genvar k = 0; k < C_WORDS_PER_BEAT; k++) begin : g_slot
            cnn_layer_accel_seq_word u_word (
                .grp   (slot_ptr[k].grp),
                .pos   (slot_ptr[k].pos),
                .valid (slot_ptr[k].grp < g_cnt),
                .word  (beat_nxt[k])
            );
            assign slot_ptr[k+1] = next_ptr(slot_ptr[k], C_GROUP_LEN);
        end
    endgenerate

    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr_q        <= '0;
            g_cnt_q      <= '0;
            beat_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            config_valid <= 1'b0;
            config_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_LOAD;
                        busy         <= 1'b1;
                        config_valid <= 1'b1;
                        config_data  <= beat_nxt;
                        ptr_q        <= slot_ptr[C_WORDS_PER_BEAT];
                        g_cnt_q      <= g_cnt;
                        beat_cnt     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (beat_take) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state        <= ST_FIN;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                            config_valid <= 1'b0;
                            config_data  <= '0;
                        end else begin
                            beat_cnt    <= beat_cnt + BEAT_W'(1);
                            config_data <= beat_nxt;
                            ptr_q       <= slot_ptr[C_WORDS_PER_BEAT];
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    config_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_seq_gen.sv
// Directed bench for the config-sequence generator: per-scenario tasks compare
// captured beats against hand constants and an index-based word model.
module tb_cnn_layer_accel_seq_gen;

    localparam int NB = 512;

    logic         clk_if = 1'b0;
    logic         rst_n;
    logic         start;
    logic [9:0]   cfg_num_groups;
    logic         busy, done, config_valid;
    logic         config_accept;
    logic [127:0] config_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] cap [0:NB-1];
    int cap_n, done_cnt, bubbles, unstable, valid_after;

    localparam logic [127:0] BEAT0_FULL =
        {16'h0201, 16'h0402, 16'h0801, 16'h1202, 16'h0201, 16'h0200, 16'h0002, 16'h0C00};
    localparam logic [127:0] BEAT0_ONE =
        {16'h0000, 16'h0000, 16'h0000, 16'h1202, 16'h0201, 16'h0200, 16'h0002, 16'h0C00};

    cnn_layer_accel_seq_gen dut (
        .clk_if         (clk_if),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_num_groups (cfg_num_groups),
        .busy           (busy),
        .done           (done),
        .config_valid   (config_valid),
        .config_accept  (config_accept),
        .config_data    (config_data)
    );

    always #5 clk_if = ~clk_if;

    function automatic logic [15:0] mdl_word(input int G, input int n);
        int g, p, s;
        logic [15:0] w;
        g = n / 5;
        p = n % 5;
        w = '0;
        s = 0;
        if (g < G) begin
            case (p)
                0: begin s = g; w[11] = 1'b1; w[10] = (g % 2 == 0); end
                1: begin s = 2 + 2 * (g / 2); w[10] = (g % 2 == 1); end
                2: s = 512 + g;
                3: s = 513 + g;
                4: begin s = 514 + g; w[12] = 1'b1; end
                default: s = 0;
            endcase
            w[9:0] = 10'(s % 1024);
        end
        return w;
    endfunction

    function automatic logic [127:0] mdl_beat(input int G, input int b);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = mdl_word(G, b * 8 + k);
        return r;
    endfunction

    function automatic int model_errs(input int G);
        int bad;
        bad = 0;
        for (int b = 0; b < cap_n; b++) if (cap[b] !== mdl_beat(G, b)) bad++;
        return bad;
    endfunction

    task automatic begin_load(input logic [9:0] g);
        @(negedge clk_if);
        cfg_num_groups = g;
        start = 1'b1;
        @(negedge clk_if);
        start = 1'b0;
    endtask

    // Collects accepted beats; mode 0 always-accept, 1 random accept,
    // 2 always-accept with extra start pulses mid-load.
    task automatic capture(input int mode);
        logic [127:0] prev_data;
        logic stalled, acc;
        int post;
        cap_n = 0; done_cnt = 0; bubbles = 0; unstable = 0; valid_after = 0;
        post = 0; stalled = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 4000 && post < 3; cyc++) begin
            if (done) done_cnt++;
            if (cap_n == NB) begin
                start = 1'b0;
                if (config_valid) valid_after++;
                post++;
            end else begin
                if (stalled && config_data !== prev_data) unstable++;
                if (!config_valid) bubbles++;
                acc = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                config_accept = acc;
                start = (mode == 2 && (cap_n == 50 || cap_n == 300));
                if (config_valid && acc) begin
                    cap[cap_n] = config_data;
                    cap_n++;
                end
                stalled = config_valid && !acc;
                prev_data = config_data;
            end
            @(negedge clk_if);
        end
        config_accept = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; config_accept = 1'b0; cfg_num_groups = '0;
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (config_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b required 0 0 0", config_valid, busy, done);
        end
        n_tests++;
        if (config_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", config_data);
        end
        repeat (2) @(negedge clk_if);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_if);
        n_tests++;
        if (config_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_beat: valid=%b required 0", config_valid);
        end
    endtask

    task automatic test_full_load();
        begin_load(10'd0);
        n_tests++;
        if (config_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_valid_rise: valid=%b busy=%b required 1 1", config_valid, busy);
        end
        capture(0);
        n_tests++;
        if (cap_n != NB) begin n_fail++; $display("FAIL full_beat_count: got %0d required %0d", cap_n, NB); end
        n_tests++;
        if (cap[0] !== BEAT0_FULL) begin n_fail++; $display("FAIL full_beat0: got %h required %h", cap[0], BEAT0_FULL); end
        n_tests++;
        if (model_errs(512) != 0) begin n_fail++; $display("FAIL full_model: mismatched beats %0d required 0", model_errs(512)); end
        n_tests++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL full_done: pulses %0d required 1", done_cnt); end
        n_tests++;
        if (bubbles != 0) begin n_fail++; $display("FAIL full_bubbles: got %0d required 0", bubbles); end
        n_tests++;
        if (valid_after != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_after_last: valid cycles %0d busy %b required 0 0", valid_after, busy);
        end
    endtask

    task automatic test_single_group();
        int nz;
        begin_load(10'd1);
        capture(0);
        nz = 0;
        for (int b = 1; b < cap_n; b++) if (cap[b] !== 128'h0) nz++;
        n_tests++;
        if (cap[0] !== BEAT0_ONE) begin n_fail++; $display("FAIL one_beat0: got %h required %h", cap[0], BEAT0_ONE); end
        n_tests++;
        if (cap_n != NB || nz != 0) begin
            n_fail++;
            $display("FAIL one_padding: beats %0d nonzero %0d required %0d 0", cap_n, nz, NB);
        end
        n_tests++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL one_done: pulses %0d required 1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [127:0] b;
        begin_load(10'd513);
        capture(0);
        b = cap[319];
        n_tests++;
        if (b[3*16 +: 16] !== 16'h09FF) begin n_fail++; $display("FAIL wrap_w0: got %h required 09ff", b[3*16 +: 16]); end
        n_tests++;
        if (b[5*16 +: 16] !== 16'h03FF) begin n_fail++; $display("FAIL wrap_w2: got %h required 03ff", b[5*16 +: 16]); end
        n_tests++;
        if (b[7*16 +: 16] !== 16'h1001) begin n_fail++; $display("FAIL wrap_w4: got %h required 1001", b[7*16 +: 16]); end
        n_tests++;
        if (cap[320] !== 128'h0 || cap[NB-1] !== 128'h0) begin
            n_fail++;
            $display("FAIL wrap_pad: beat320 %h beat511 %h required 0", cap[320], cap[NB-1]);
        end
        n_tests++;
        if (model_errs(512) != 0 || cap_n != NB) begin
            n_fail++;
            $display("FAIL wrap_model: mismatched %0d beats %0d required 0 %0d", model_errs(512), cap_n, NB);
        end
    endtask

    task automatic test_stall();
        begin_load(10'd0);
        capture(1);
        n_tests++;
        if (unstable != 0) begin n_fail++; $display("FAIL stall_stable: changes %0d required 0", unstable); end
        n_tests++;
        if (cap_n != NB || model_errs(512) != 0) begin
            n_fail++;
            $display("FAIL stall_model: beats %0d mismatched %0d required %0d 0", cap_n, model_errs(512), NB);
        end
        n_tests++;
        if (bubbles != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL stall_ctrl: valid drops %0d done %0d required 0 1", bubbles, done_cnt);
        end
    endtask

    task automatic test_restart_ignored();
        begin_load(10'd7);
        capture(2);
        n_tests++;
        if (cap_n != NB || done_cnt != 1) begin
            n_fail++;
            $display("FAIL restart_count: beats %0d done %0d required %0d 1", cap_n, done_cnt, NB);
        end
        n_tests++;
        if (model_errs(7) != 0) begin n_fail++; $display("FAIL restart_model: mismatched %0d required 0", model_errs(7)); end
    endtask

    task automatic test_reset_midload();
        int taken, seen;
        begin_load(10'd0);
        config_accept = 1'b1;
        taken = 0;
        for (int c = 0; c < 400 && taken < 100; c++) begin
            if (config_valid) taken++;
            @(negedge clk_if);
        end
        n_tests++;
        if (taken != 100) begin n_fail++; $display("FAIL mid_reach: beats %0d required 100", taken); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (config_valid !== 1'b0 || busy !== 1'b0 || config_data !== 128'h0) begin
            n_fail++;
            $display("FAIL mid_async: valid=%b busy=%b data=%h required 0 0 0", config_valid, busy, config_data);
        end
        @(negedge clk_if);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_if);
            if (config_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL mid_quiet: valid cycles %0d required 0", seen); end
        config_accept = 1'b0;
        begin_load(10'd0);
        n_tests++;
        if (config_valid !== 1'b1 || config_data !== BEAT0_FULL) begin
            n_fail++;
            $display("FAIL mid_restart: valid=%b data=%h required 1 %h", config_valid, config_data, BEAT0_FULL);
        end
        rst_n = 1'b0;
        @(negedge clk_if);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_single_group();
        test_wrap();
        test_stall();
        test_restart_ignored();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
